decode_stage: RTL and testbench

Registered, parametrised instruction decoder stage for the accumulator core. It accepts one instruction word per cycle over a valid/ready handshake and decodes it into the control bundle: register write strobe, data-memory write, data-source select, ALU code, and carry/accumulator enables. The decoded bundle is held in an output register behind a 2-entry skid buffer, so fetch and execute can stall independently without dropping or duplicating instructions. It sits between the program-memory fetch and the execute stage.

---
 rtl/decode_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered instruction decoder with a 2-entry skid buffer (output slot O + skid slot S).
// Optional macro DECODE_ILLEGAL_TRAP_EN adds a sticky 'halted' trap on draining an illegal bundle.
module decode_stage #(
    parameter  int DATA_WIDTH = 8,
    parameter  int REG_COUNT  = 4,
    localparam int INS_W      = 5 + DATA_WIDTH,
    localparam int REG_SEL_W  = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INS_W-1:0]      ins,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_COUNT-1:0]  reg_we,
    output logic [REG_COUNT-1:0]  reg_sel,
    output logic                  dm_we,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            sel_data_source,
    output logic [2:0]            alu_code,
    output logic                  carry_ce,
    output logic                  accu_ce,
    output logic                  illegal
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                  halted
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [REG_COUNT-1:0]  reg_sel;
        logic [1:0]            sel;
        logic [2:0]            alu_code;
        logic                  st_r;
        logic                  dm_we;
        logic                  carry_ce;
        logic                  accu_ce;
        logic                  illegal;
    } bundle_t;

    function automatic bundle_t idle_bundle();
        bundle_t b;
        b.data     = '0;
        b.reg_sel  = REG_COUNT'(1);
        b.sel      = 2'd0;
        b.alu_code = 3'd7;
        b.st_r     = 1'b0;
        b.dm_we    = 1'b0;
        b.carry_ce = 1'b0;
        b.accu_ce  = 1'b0;
        b.illegal  = 1'b0;
        return b;
    endfunction

    function automatic bundle_t decode(input logic [INS_W-1:0] w);
        bundle_t                 b;
        logic [1:0]              section;
        logic [2:0]              sub;
        logic [DATA_WIDTH-1:0]   field;
        logic [REG_SEL_W-1:0]    rnum;
        section   = w[INS_W-1 -: 2];
        sub       = w[INS_W-3 -: 3];
        field     = w[DATA_WIDTH-1:0];
        rnum      = field[DATA_WIDTH-1 -: REG_SEL_W];
        b         = idle_bundle();
        b.data    = field;
        b.reg_sel = REG_COUNT'(1) << rnum;
        if (section != 2'd3) begin
            // Arithmetic/logic sections: the section number doubles as the operand source.
            if (sub <= 3'd4) begin
                b.alu_code = sub;
                b.accu_ce  = 1'b1;
                b.sel      = section;
                b.carry_ce = (sub < 3'd2);
            end else begin
                b.illegal  = 1'b1;
            end
        end else begin
            case (sub)
                3'd0, 3'd1, 3'd2: begin
                    b.alu_code = 3'd5;
                    b.accu_ce  = 1'b1;
                    b.sel      = sub[1:0];
                end
                3'd3:    b.st_r  = 1'b1;
                3'd4:    b.dm_we = 1'b1;
                3'd5: begin
                    b.alu_code = 3'd6;
                    b.accu_ce  = 1'b1;
                end
                3'd6:    b.st_r  = 1'b0;
                default: b.illegal = 1'b1;
            endcase
        end
        return b;
    endfunction

    bundle_t bnd_o_p1, bnd_s_p0;
    logic    vld_o_p1, vld_s_p0;
    logic    halt_p1;
    logic    accept, drain;

    assign in_ready  = !vld_s_p0 && !halt_p1;
    assign out_valid = vld_o_p1 && !halt_p1;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Stage p0 -> p1: skid slot S feeds output slot O; S only fills while O is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_o_p1 <= 1'b0;
            vld_s_p0 <= 1'b0;
            bnd_o_p1 <= idle_bundle();
            bnd_s_p0 <= idle_bundle();
        end else if (flush && !halt_p1) begin
            vld_o_p1 <= 1'b0;
            vld_s_p0 <= 1'b0;
        end else if (drain) begin
            if (vld_s_p0) begin
                bnd_o_p1 <= bnd_s_p0;
                vld_s_p0 <= 1'b0;
            end else if (accept) begin
                bnd_o_p1 <= decode(ins);
            end else begin
                vld_o_p1 <= 1'b0;
            end
        end else if (accept) begin
            if (!vld_o_p1) begin
                bnd_o_p1 <= decode(ins);
                vld_o_p1 <= 1'b1;
            end else begin
                bnd_s_p0 <= decode(ins);
                vld_s_p0 <= 1'b1;
            end
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_p1 <= 1'b0;
        end else if (drain && bnd_o_p1.illegal) begin
            halt_p1 <= 1'b1;
        end
    end
    assign halted = halt_p1;
`else
    assign halt_p1 = 1'b0;
`endif

    assign reg_we          = (out_valid && bnd_o_p1.st_r) ? bnd_o_p1.reg_sel : '0;
    assign reg_sel         = bnd_o_p1.reg_sel;
    assign dm_we           = out_valid && bnd_o_p1.dm_we;
    assign data            = bnd_o_p1.data;
    assign sel_data_source = bnd_o_p1.sel;
    assign alu_code        = bnd_o_p1.alu_code;
    assign carry_ce        = out_valid && bnd_o_p1.carry_ce;
    assign accu_ce         = out_valid && bnd_o_p1.accu_ce;
    assign illegal         = out_valid && bnd_o_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage (REG_COUNT 4 and 16 instances share stimulus).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [12:0] ins;

    logic        in_ready, out_valid, dm_we, carry_ce, accu_ce, illegal;
    logic [3:0]  reg_we, reg_sel;
    logic [7:0]  data;
    logic [1:0]  sel;
    logic [2:0]  alu_code;

    logic        in_ready16, out_valid16, dm_we16, carry_ce16, accu_ce16, illegal16;
    logic [15:0] reg_we16, reg_sel16;
    logic [7:0]  data16;
    logic [1:0]  sel16;
    logic [2:0]  alu_code16;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        halted, halted16;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_WIDTH(8), .REG_COUNT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ins(ins), .out_valid(out_valid), .out_ready(out_ready), .reg_we(reg_we),
        .reg_sel(reg_sel), .dm_we(dm_we), .data(data), .sel_data_source(sel),
        .alu_code(alu_code), .carry_ce(carry_ce), .accu_ce(accu_ce), .illegal(illegal)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .halted(halted)
`endif
    );

    decode_stage #(.DATA_WIDTH(8), .REG_COUNT(16)) dut16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
        .ins(ins), .out_valid(out_valid16), .out_ready(out_ready), .reg_we(reg_we16),
        .reg_sel(reg_sel16), .dm_we(dm_we16), .data(data16), .sel_data_source(sel16),
        .alu_code(alu_code16), .carry_ce(carry_ce16), .accu_ce(accu_ce16), .illegal(illegal16)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .halted(halted16)
`endif
    );

    typedef struct {
        logic [12:0] ins;
        logic [2:0]  alu;
        logic        accu;
        logic        carry;
        logic [1:0]  sel;
        logic        dm;
        logic [3:0]  we;
        logic [3:0]  rs;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [12:0] mk(input logic [1:0] sec, input logic [2:0] sub,
                                       input logic [7:0] f);
        return {sec, sub, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [12:0] w);
        in_valid = 1'b1;
        ins      = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{mk(2'd0, 3'd0, 8'h80), 3'd0, 1, 1, 2'd0, 0, 4'h0, 4'h4};
        vecs[1]  = '{mk(2'd3, 3'd4, 8'h5A), 3'd7, 0, 0, 2'd0, 1, 4'h0, 4'h2};
        vecs[2]  = '{mk(2'd3, 3'd2, 8'h33), 3'd5, 1, 0, 2'd2, 0, 4'h0, 4'h1};
        vecs[3]  = '{mk(2'd1, 3'd1, 8'h10), 3'd1, 1, 1, 2'd1, 0, 4'h0, 4'h1};
        vecs[4]  = '{mk(2'd2, 3'd2, 8'hC3), 3'd2, 1, 0, 2'd2, 0, 4'h0, 4'h8};
        vecs[5]  = '{mk(2'd0, 3'd3, 8'h47), 3'd3, 1, 0, 2'd0, 0, 4'h0, 4'h2};
        vecs[6]  = '{mk(2'd1, 3'd4, 8'h9E), 3'd4, 1, 0, 2'd1, 0, 4'h0, 4'h4};
        vecs[7]  = '{mk(2'd3, 3'd0, 8'h21), 3'd5, 1, 0, 2'd0, 0, 4'h0, 4'h1};
        vecs[8]  = '{mk(2'd3, 3'd1, 8'hF0), 3'd5, 1, 0, 2'd1, 0, 4'h0, 4'h8};
        vecs[9]  = '{mk(2'd3, 3'd3, 8'h40), 3'd7, 0, 0, 2'd0, 0, 4'h2, 4'h2};
        vecs[10] = '{mk(2'd3, 3'd5, 8'h00), 3'd6, 1, 0, 2'd0, 0, 4'h0, 4'h1};
        vecs[11] = '{mk(2'd3, 3'd6, 8'hBB), 3'd7, 0, 0, 2'd0, 0, 4'h0, 4'h4};
        vecs[12] = '{mk(2'd2, 3'd4, 8'h7F), 3'd4, 1, 0, 2'd2, 0, 4'h0, 4'h2};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ins = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst reg_we", reg_we, 0);
        chk("rst reg_sel", reg_sel, 4'b0001);
        chk("rst dm_we", dm_we, 0);
        chk("rst data", data, 0);
        chk("rst sel", sel, 0);
        chk("rst alu_code", alu_code, 7);
        chk("rst carry_ce", carry_ce, 0);
        chk("rst accu_ce", accu_ce, 0);
        chk("rst illegal", illegal, 0);
        chk("rst reg_sel16", reg_sel16, 16'h0001);

        // Back-to-back stream, one bundle per cycle
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].ins);
            tick();
            chk($sformatf("v%0d out_valid", i), out_valid, 1);
            chk($sformatf("v%0d in_ready", i), in_ready, 1);
            chk($sformatf("v%0d alu_code", i), alu_code, vecs[i].alu);
            chk($sformatf("v%0d accu_ce", i), accu_ce, vecs[i].accu);
            chk($sformatf("v%0d carry_ce", i), carry_ce, vecs[i].carry);
            chk($sformatf("v%0d sel", i), sel, vecs[i].sel);
            chk($sformatf("v%0d dm_we", i), dm_we, vecs[i].dm);
            chk($sformatf("v%0d reg_we", i), reg_we, vecs[i].we);
            chk($sformatf("v%0d reg_sel", i), reg_sel, vecs[i].rs);
            chk($sformatf("v%0d data", i), data, vecs[i].ins[7:0]);
            chk($sformatf("v%0d illegal", i), illegal, 0);
        end
        in_valid = 1'b0;
        tick();
        chk("idle out_valid", out_valid, 0);
        chk("idle accu_ce", accu_ce, 0);
        chk("idle data hold", data, 8'h7F);
        chk("idle sel hold", sel, 2);

        // Stall: 3 instructions with out_ready low
        out_ready = 1'b0;
        send(mk(2'd3, 3'd2, 8'h11));
        tick();
        chk("stall o1 data", data, 8'h11);
        chk("stall o1 in_ready", in_ready, 1);
        send(mk(2'd3, 3'd2, 8'h22));
        tick();
        chk("stall s full in_ready", in_ready, 0);
        chk("stall hold data", data, 8'h11);
        send(mk(2'd3, 3'd2, 8'h33));
        tick();
        chk("stall3 in_ready", in_ready, 0);
        chk("stall3 stable data", data, 8'h11);
        chk("stall3 out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("drain2 data", data, 8'h22);
        chk("drain2 in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("drain3 data", data, 8'h33);
        chk("drain3 out_valid", out_valid, 1);
        tick();
        chk("drain end out_valid", out_valid, 0);

        // Flush with O and S full and an incoming instruction
        out_ready = 1'b0;
        send(mk(2'd3, 3'd2, 8'h41));
        tick();
        send(mk(2'd3, 3'd2, 8'h42));
        tick();
        chk("pre-flush in_ready", in_ready, 0);
        flush = 1'b1;
        send(mk(2'd3, 3'd2, 8'h44));
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        tick();
        chk("flush stays empty", out_valid, 0);
        flush = 1'b1;
        send(mk(2'd3, 3'd2, 8'h55));
        tick();
        flush = 1'b0;
        chk("flush drop accept", out_valid, 0);
        send(mk(2'd3, 3'd2, 8'h66));
        tick();
        in_valid = 1'b0;
        chk("post-flush data", data, 8'h66);
        chk("post-flush out_valid", out_valid, 1);

        // Asynchronous reset while O holds a bundle
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst alu_code", alu_code, 7);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("after rst out_valid", out_valid, 0);

        // ST_R rnum 13 on the 16-register instance
        send(mk(2'd3, 3'd3, 8'hD0));
        tick();
        in_valid = 1'b0;
        chk("st_r16 reg_we16", reg_we16, 16'h2000);
        chk("st_r16 reg_we4", reg_we, 4'b1000);
        tick();
        chk("st_r16 one cycle", reg_we16, 16'h0000);
        chk("st_r16 reg_sel held", reg_sel16, 16'h2000);

        // Illegal opcode
        send(mk(2'd1, 3'd6, 8'h00));
        tick();
        in_valid = 1'b0;
        chk("ill illegal", illegal, 1);
        chk("ill alu_code", alu_code, 7);
        chk("ill accu_ce", accu_ce, 0);
        chk("ill carry_ce", carry_ce, 0);
        chk("ill dm_we", dm_we, 0);
        chk("ill out_valid", out_valid, 1);
        tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("trap halted", halted, 1);
        chk("trap in_ready", in_ready, 0);
        chk("trap out_valid", out_valid, 0);
        flush = 1'b1;
        send(mk(2'd3, 3'd5, 8'h00));
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("trap flush ignored", halted, 1);
        chk("trap still blocked", in_ready, 0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("trap cleared", halted, 0);
        chk("trap in_ready back", in_ready, 1);
`else
        chk("ill no trap in_ready", in_ready, 1);
        send(mk(2'd3, 3'd5, 8'h00));
        tick();
        in_valid = 1'b0;
        chk("ill continue alu", alu_code, 6);
        chk("ill continue accu", accu_ce, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
